bp_resolve: RTL
===============

# bp_resolve

Branch resolution queue between fetch and execute. Fetch pushes each prediction it makes (fetch PC, predicted target, predicted direction). Execute later pops the oldest entry with the actual outcome. The block compares prediction against outcome and produces the predictor update (`upd_wrong`, `upd_addr`, `upd_next`, `upd_pc`), plus a one-cycle pipeline flush and redirect on mispredict.

## Interface
Parameters:
- `DEPTH`, default 4: in-flight prediction entries; power of 2, 2 to 16.
- `AW`, default 12: PC/address width.

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `clear_n` in 1: reset is synchronous and active-low.
- `push_valid` in 1: fetch offers a prediction record.
- `push_pc` in AW: PC at fetch time.
- `push_target` in AW: predicted target.
- `push_taken` in 1: predicted direction.
- `push_ready` out 1: record accepted this cycle when high together with `push_valid`.
- `res_valid` in 1: execute resolves the oldest control transfer.
- `res_taken` in 1: actual direction.
- `res_target` in AW: actual target; ignored when `res_taken`=0.
- `res_ready` out 1: resolution accepted when high together with `res_valid`.
- `upd_wrong` out 1: predictor write enable; 1-cycle pulse.
- `upd_pc` out AW: PC of the resolved entry (predictor write index).
- `upd_addr` out AW: correct next address.
- `upd_next` out AW: `upd_pc`+1.
- `flush` out 1: 1-cycle pulse; squash the younger pipeline.
- `redirect_pc` out AW: fetch restart address; valid while `flush`=1.
- `count` out $clog2(DEPTH)+1: occupied entries.

## Operation
- Storage: circular buffer of DEPTH entries {pc, target, taken}, with write pointer, read pointer and occupancy count. Pointers wrap modulo DEPTH.
- Push accepted: `push_valid`&&`push_ready`. The entry is written at wrptr and wrptr advances.
- Pop accepted: `res_valid`&&`res_ready`. The entry at rdptr is resolved and rdptr advances.
- Resolution arithmetic (all mod 2^AW, so PC 0xFFF+1 = 0x000):
  - predicted = taken ? target : pc+1
  - correct = `res_taken` ? `res_target` : pc+1
  - wrong = (predicted != correct)
  - A mispredicted direction and a correct-direction/wrong-target case both count as wrong.
- FSM has two states: RUN and FLUSH.
  - RUN: `push_ready` = (count < DEPTH); `res_ready` = (count > 0).
  - RUN to FLUSH: on an accepted pop with wrong=1. That same edge clears all entries, resets both pointers and sets count=0. Every remaining entry is wrong-path.
  - FLUSH: lasts exactly one cycle. `push_ready`=0, `res_ready`=0, `flush`=1, `redirect_pc`=correct. The next state is always RUN.
- Simultaneous push and pop in RUN:
  - With no mispredict, both take effect and count is unchanged.
  - With a mispredict, the push is discarded and count becomes 0.
- Full: `push_ready` is 0 even if a pop is accepted the same cycle.
- Empty: `res_ready`=0; `res_valid` is ignored and produces no update.
- Every accepted pop, correct or not, loads `upd_pc`, `upd_addr` and `upd_next` on the edge. `upd_wrong` is loaded with wrong.

## Timing
- Reset (`clear_n`=0 at an edge):
  - State RUN; pointers and count 0.
  - `upd_wrong`=0, `flush`=0.
  - `upd_pc`, `upd_addr`, `upd_next`, `redirect_pc` = 0.
  - Reset has priority over any same-cycle push or pop.
  - Reset during FLUSH returns to RUN with `flush`=0 next cycle.
- `push_ready` and `res_ready` are combinational from state and count only. They never depend on `push_valid` or `res_valid`.
- Pop accepted at edge N: `upd_*` and `flush` are valid in the cycle after edge N. `upd_wrong`/`flush` are high for exactly that one cycle.
- Back-to-back correct pops: one per cycle, with no bubble.
- After a mispredict pop at edge N: FLUSH occupies the cycle after N. The earliest next push is accepted at edge N+2.

## Configuration
- `BP_RESOLVE_STATS_EN` defined: adds output ports `stat_resolved` and `stat_wrong`, each 16 bits.
  - `stat_resolved` counts accepted pops; `stat_wrong` counts mispredicts.
  - Both saturate at 0xFFFF and are cleared by `clear_n`.
- Not defined: the ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then push {pc=0x010, tgt=0x020, taken=1}. Resolve with taken=1, target=0x020. Next cycle: `upd_wrong`=0, `upd_pc`=0x010, `upd_addr`=0x020, `flush`=0, `count`=0.
- Push pc=0x005 predicted taken to 0x040. Resolve not-taken. Next cycle: `upd_wrong`=1, `upd_addr`=0x006, `upd_next`=0x006, `flush`=1, `redirect_pc`=0x006. Following cycle: `flush`=0 and state is RUN.
- Push 3 entries, then resolve the first as a mispredict while `push_valid`=1 the same cycle. Result: `count`=0, the same-cycle push is dropped, and `push_ready`=0 for one cycle.
- Push DEPTH=4 entries: `push_ready`=0. Then pop and push in the same cycle: the push is not accepted and `count`=3. Continue pushes and pops for 10 cycles to exercise pointer wrap; entries must return in FIFO order.
- Push pc=0xFFF predicted not-taken. Resolve not-taken: `upd_wrong`=0, `upd_addr`=0x000. Also assert `res_valid` while empty: no `upd_*` pulse.
- With `BP_RESOLVE_STATS_EN`: 5 pops with 2 mispredicts give `stat_resolved`=5 and `stat_wrong`=2. Reset returns both to 0.

Source files
------------

// File: rtl/bp_resolve.sv
// bp_resolve: branch prediction resolution queue producing predictor updates and mispredict flush/redirect.
// Define BP_RESOLVE_STATS_EN to add saturating stat_resolved / stat_wrong counters.
module bp_resolve #(
    parameter int DEPTH = 4,
    parameter int AW = 12
) (
    input  logic                    clock,
    input  logic                    clear_n,
    input  logic                    push_valid,
    input  logic [AW-1:0]           push_pc,
    input  logic [AW-1:0]           push_target,
    input  logic                    push_taken,
    output logic                    push_ready,
    input  logic                    res_valid,
    input  logic                    res_taken,
    input  logic [AW-1:0]           res_target,
    output logic                    res_ready,
    output logic                    upd_wrong,
    output logic [AW-1:0]           upd_pc,
    output logic [AW-1:0]           upd_addr,
    output logic [AW-1:0]           upd_next,
    output logic                    flush,
    output logic [AW-1:0]           redirect_pc,
    output logic [$clog2(DEPTH):0]  count
`ifdef BP_RESOLVE_STATS_EN
    ,
    output logic [15:0]             stat_resolved,
    output logic [15:0]             stat_wrong
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {RUN, FLUSH} stateType;

    stateType      state;
    logic [AW-1:0] pcMem [DEPTH];
    logic [AW-1:0] tgtMem [DEPTH];
    logic [DEPTH-1:0] takenMem;
    logic [PW-1:0] wrPtr, rdPtr;
    logic [AW-1:0] headPc, headNext, predicted, correct;
    logic          pushFire, popFire, wrong, pushWrite;

    assign push_ready = (state == RUN) && (count < CW'(DEPTH));
    assign res_ready  = (state == RUN) && (count != '0);
    assign pushFire   = push_valid && push_ready;
    assign popFire    = res_valid && res_ready;
    assign headPc     = pcMem[rdPtr];
    assign headNext   = headPc + AW'(1);
    assign predicted  = takenMem[rdPtr] ? tgtMem[rdPtr] : headNext;
    assign correct    = res_taken ? res_target : headNext;
    assign wrong      = predicted != correct;
    // A mispredict squashes everything younger, including a same-cycle push.
    assign pushWrite  = pushFire && !(popFire && wrong);

    always_ff @(posedge clock) begin
        if (pushWrite) begin
            pcMem[wrPtr]    <= push_pc;
            tgtMem[wrPtr]   <= push_target;
            takenMem[wrPtr] <= push_taken;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state       <= RUN;
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            upd_wrong   <= 1'b0;
            flush       <= 1'b0;
            upd_pc      <= '0;
            upd_addr    <= '0;
            upd_next    <= '0;
            redirect_pc <= '0;
        end else begin
            upd_wrong <= 1'b0;
            flush     <= 1'b0;
            if (popFire) begin
                upd_pc    <= headPc;
                upd_addr  <= correct;
                upd_next  <= headNext;
                upd_wrong <= wrong;
            end
            case (state)
                RUN: begin
                    if (popFire && wrong) begin
                        state       <= FLUSH;
                        flush       <= 1'b1;
                        redirect_pc <= correct;
                        wrPtr       <= '0;
                        rdPtr       <= '0;
                        count       <= '0;
                    end else begin
                        if (pushFire) wrPtr <= wrPtr + 1'b1;
                        if (popFire) rdPtr <= rdPtr + 1'b1;
                        count <= count + CW'(pushFire) - CW'(popFire);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef BP_RESOLVE_STATS_EN
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            stat_resolved <= '0;
            stat_wrong    <= '0;
        end else if (popFire) begin
            if (stat_resolved != '1) stat_resolved <= stat_resolved + 16'd1;
            if (wrong && stat_wrong != '1) stat_wrong <= stat_wrong + 16'd1;
        end
    end
`endif
endmodule
